// File: rtl/object_spawner.sv
// Falling-object spawner: after a frame-counted wait, presents an LFSR-derived column for a
// limited number of frames (or until hit). Optional macro SPAWNER_SPEEDUP_EN shortens the wait over time.
module object_spawner #(
    parameter int          SCREEN_W      = 640,
    parameter int          OBJECT_W      = 50,
    parameter int          UNDEFINED_POS = 1000,
    parameter int          SPAWN_PERIOD  = 120,
    parameter int          ACTIVE_FRAMES = 96,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        v_sync,
    input  logic        enable,
    input  logic        hit,
    output logic [10:0] object_position,
    output logic        object_active,
    output logic [7:0]  spawn_count
);

    localparam logic [9:0]  LIM       = 10'(SCREEN_W - OBJECT_W);
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [10:0] UNDEF     = 11'(UNDEFINED_POS);
    localparam logic [8:0]  ACT_LAST  = 9'(ACTIVE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE
    } state_t;

    state_t      r_state;
    logic        r_v_sync_d;
    logic [15:0] r_lfsr;
    logic [7:0]  r_frame_ctr;
    logic [10:0] r_position;
    logic        r_active;
    logic [7:0]  r_spawn_count;

    logic        w_tick;
    logic [8:0]  w_period_last;
    logic        w_wait_done;
    logic        w_active_done;
    logic        w_spawn;
    logic [7:0]  w_count_next;

    // Galois step, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Fold the 10-bit random value into 0..LIM-1 with a single conditional subtract
    function automatic logic [10:0] map_pos(input logic [9:0] r);
        return (r >= LIM) ? {1'b0, r - LIM} : {1'b0, r};
    endfunction

    assign w_tick = v_sync & ~r_v_sync_d;

`ifdef SPAWNER_SPEEDUP_EN
    logic [8:0] r_period;
    logic       w_speedup;

    assign w_period_last = r_period - 9'd1;
    // The low three bits roll over on every 8th counted spawn; a saturated counter no longer counts
    assign w_speedup     = (r_spawn_count != 8'hFF) && (r_spawn_count[2:0] == 3'd7);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_period <= 9'(SPAWN_PERIOD);
        end else if (w_spawn && w_speedup) begin
            if (r_period >= 9'd40) begin
                r_period <= r_period - 9'd8;
            end else if (r_period > 9'd32) begin
                r_period <= 9'd32;
            end
        end
    end
`else
    assign w_period_last = 9'(SPAWN_PERIOD - 1);
`endif

    assign w_wait_done   = ({1'b0, r_frame_ctr} == w_period_last);
    assign w_active_done = ({1'b0, r_frame_ctr} == ACT_LAST);
    assign w_spawn       = enable && (r_state == S_WAIT) && w_tick && w_wait_done;
    assign w_count_next  = (r_spawn_count == 8'hFF) ? 8'hFF : r_spawn_count + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_v_sync_d    <= 1'b0;
            r_lfsr        <= SEED;
            r_frame_ctr   <= 8'd0;
            r_position    <= UNDEF;
            r_active      <= 1'b0;
            r_spawn_count <= 8'd0;
        end else begin
            r_v_sync_d <= v_sync;
            r_lfsr     <= lfsr_step(r_lfsr);
            if (!enable) begin
                r_state     <= S_IDLE;
                r_position  <= UNDEF;
                r_active    <= 1'b0;
                r_frame_ctr <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state     <= S_WAIT;
                        r_frame_ctr <= 8'd0;
                    end
                    S_WAIT: begin
                        if (w_spawn) begin
                            r_state       <= S_ACTIVE;
                            r_position    <= map_pos(r_lfsr[9:0]);
                            r_active      <= 1'b1;
                            r_frame_ctr   <= 8'd0;
                            r_spawn_count <= w_count_next;
                        end else if (w_tick) begin
                            r_frame_ctr <= r_frame_ctr + 8'd1;
                        end
                    end
                    S_ACTIVE: begin
                        // A hit swallows a coincident tick so the following wait is a full period
                        if (hit || (w_tick && w_active_done)) begin
                            r_state     <= S_WAIT;
                            r_position  <= UNDEF;
                            r_active    <= 1'b0;
                            r_frame_ctr <= 8'd0;
                        end else if (w_tick) begin
                            r_frame_ctr <= r_frame_ctr + 8'd1;
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_position  <= UNDEF;
                        r_active    <= 1'b0;
                        r_frame_ctr <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign object_position = r_position;
    assign object_active   = r_active;
    assign spawn_count     = r_spawn_count;

endmodule

// File: doc/object_spawner.md
# object_spawner

Generates the falling-object x-position consumed by the VGA synchronization/draw stage. Once per configurable number of video frames, it picks a pseudo-random column from a free-running LFSR and presents it on `object_position`. It holds that value for a fixed number of frames, or until a hit is reported. At all other times it drives the UNDEFINED sentinel (1000), which tells the draw stage that no object is pending.

## Interface
- `SCREEN_W`, 640, visible width in pixels
- `OBJECT_W`, 50, object width in pixels; legal positions are 0..SCREEN_W-OBJECT_W-1
- `UNDEFINED_POS`, 1000, sentinel driven when no object is live
- `SPAWN_PERIOD`, 120, frames spent in WAIT before each spawn (≥2)
- `ACTIVE_FRAMES`, 96, frames an object stays live (≥1)
- `LFSR_SEED`, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001

- `clk`  in  1  pixel clock, the same clock as the draw stage
- `reset`  in  1  synchronous, active-low
- `v_sync`  in  1  vertical sync from the draw stage; its rising edge marks the frame tick
- `enable`  in  1  game running; when low, the block returns to IDLE
- `hit`  in  1  single-cycle pulse: the live object was destroyed
- `object_position`  out  11  x-position of the live object, or UNDEFINED_POS
- `object_active`  out  1  high while `object_position` ≠ UNDEFINED_POS
- `spawn_count`  out  8  number of spawns since reset; saturates at 255

## Operation
- **Reset values** (reset = 0 on a clk edge): `object_position`=UNDEFINED_POS, `object_active`=0, `spawn_count`=0, state=IDLE, `frame_ctr`=0, `lfsr`=LFSR_SEED (or 1 if the seed is 0), `v_sync_d`=0.
- **Frame tick:** `tick = v_sync & ~v_sync_d`, where `v_sync_d` is `v_sync` registered once.
- **LFSR:** 16-bit Galois, polynomial mask 16'hB400. It advances every clk while not in reset, in every state.
- **Position mapping:** let `r = lfsr[9:0]` and `LIM = SCREEN_W - OBJECT_W` (590). The position is `r - LIM` if `r ≥ LIM`, else `r`. The result always falls in 0..LIM-1. The result is zero-extended to 11 bits.
- **IDLE:** outputs are UNDEFINED/0. If `enable`=1, go to WAIT with `frame_ctr`=0.
- **WAIT:**
  - On each tick, `frame_ctr++`.
  - On a tick with `frame_ctr == period-1`:
    - go to ACTIVE;
    - latch the mapped position into `object_position` from the current `lfsr`;
    - set `object_active`=1;
    - set `frame_ctr`=0;
    - set `spawn_count = min(spawn_count+1, 255)`.
- **ACTIVE:**
  - On each tick, `frame_ctr++`.
  - On a tick with `frame_ctr == ACTIVE_FRAMES-1`, go to WAIT, drive UNDEFINED_POS, set `object_active`=0 and `frame_ctr`=0.
  - If `hit`=1, the same exit is taken immediately, regardless of tick.
- **Priority (highest first):** `reset` > `enable`=0 > `hit` > tick.
  - `enable`=0 in any state: go to IDLE next cycle, drive UNDEFINED_POS, `object_active`=0, `frame_ctr`=0. `spawn_count` is kept.
  - `hit` together with a tick in ACTIVE: the hit exit applies and the tick is not counted in WAIT. The next spawn occurs exactly `period` ticks later.
  - `hit` in IDLE or WAIT: ignored.
- **Counter width:** `frame_ctr` is 8 bits; parameters must be ≤256.

## Timing
- Tick detection latency: 1 clk after `v_sync` is first sampled high.
- All outputs are registered. `object_position`/`object_active` change on the same clk edge that consumes the qualifying tick or hit. They are therefore stable for the whole frame that follows.
- `hit` to UNDEFINED_POS: 1 clk.
- `enable` falling to UNDEFINED_POS: 1 clk.
- Reset mid-ACTIVE: UNDEFINED_POS on the first edge where reset=0. No partial frame is counted after release.

## Configuration
- `SPAWNER_SPEEDUP_EN`:
  - **Defined:** the effective period starts at SPAWN_PERIOD. Every 8th spawn (`spawn_count[2:0]` wraps to 0 on an increment) reduces it by 8, with a floor of 32. If SPAWN_PERIOD < 32, the period stays at SPAWN_PERIOD. Reset restores SPAWN_PERIOD.
  - **Undefined:** the period is fixed at SPAWN_PERIOD and no period register is instantiated.

## Test plan
- Hold reset=0 for 5 clk with `enable`=1 and `v_sync` toggling → `object_position`=1000, `object_active`=0, `spawn_count`=0 throughout.
- SPAWN_PERIOD=4, ACTIVE_FRAMES=3; release reset, `enable`=1, give 4 `v_sync` rising edges → 1 clk after the 4th tick, `object_active`=1 and `object_position` equals the mapped value from the model LFSR (seeded 16'hACE1); `spawn_count`=1.
- Continue with 3 more ticks → `object_position`=1000 and `object_active`=0 after the 3rd. The next spawn follows exactly 4 ticks later.
- Drive `hit` in the same cycle as a tick during ACTIVE → 1000 on the next clk; the next spawn comes 4 ticks later, not 3. A `hit` during WAIT leaves `frame_ctr` and the outputs unchanged.
- SPAWN_PERIOD=2, 300 spawns → every position is <590 and matches the model; `spawn_count` holds at 255. Dropping `enable` mid-ACTIVE gives 1000 one clk later and keeps the count at 255.
- `SPAWNER_SPEEDUP_EN` defined, SPAWN_PERIOD=48 → spawns 1–8 are 48 ticks apart, 9–16 are 40 apart, and 17 onward are 32 apart, staying at 32.
